// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use bubble insertion.
module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int RA_W   = 5,
   parameter bit FWD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [RA_W-1:0] id_rs1,
   input  logic [RA_W-1:0] id_rs2,
   input  logic            id_uses_rs1,
   input  logic            id_uses_rs2,
   input  logic [RA_W-1:0] id_rd,
   input  logic [3:0]      id_alucontrol,
   input  logic            id_alusrc_pc,
   input  logic            id_alusrc_imm,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            id_memwrite,
   input  logic            id_branch,
   input  logic [2:0]      id_funct3,
   input  logic            mem_regwrite,
   input  logic [RA_W-1:0] mem_rd,
   input  logic [XLEN-1:0] mem_result,
   input  logic            wb_regwrite,
   input  logic [RA_W-1:0] wb_rd,
   input  logic [XLEN-1:0] wb_result,
   output logic            load_use_hold,
   output logic            ex_valid,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_control,
   output logic [XLEN-1:0] ex_store_data,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_imm,
   output logic [RA_W-1:0] ex_rd,
   output logic            ex_regwrite,
   output logic            ex_memread,
   output logic            ex_memwrite,
   output logic            ex_branch,
   output logic [2:0]      ex_funct3
);
   logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, fwd_rs1, fwd_rs2;
   logic [RA_W-1:0] ex_rs1, ex_rs2;
   logic            ex_alusrc_pc, ex_alusrc_imm;
   logic            m1, w1, m2, w2;

   assign load_use_hold = id_valid & ex_valid & ex_memread & (ex_rd != '0) &
                          ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

   // flush beats stall; a load-use bubble only happens when not stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid      <= 1'b0;
         ex_regwrite   <= 1'b0;
         ex_memread    <= 1'b0;
         ex_memwrite   <= 1'b0;
         ex_branch     <= 1'b0;
         ex_pc         <= '0;
         ex_imm        <= '0;
         ex_rs1_data   <= '0;
         ex_rs2_data   <= '0;
         ex_rs1        <= '0;
         ex_rs2        <= '0;
         ex_rd         <= '0;
         alu_control   <= 4'b0000;
         ex_alusrc_pc  <= 1'b0;
         ex_alusrc_imm <= 1'b0;
         ex_funct3     <= '0;
      end else if (flush | (!stall & load_use_hold)) begin
         ex_valid    <= 1'b0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_branch   <= 1'b0;
      end else if (!stall) begin
         ex_valid      <= id_valid;
         ex_regwrite   <= id_regwrite & id_valid;
         ex_memread    <= id_memread & id_valid;
         ex_memwrite   <= id_memwrite & id_valid;
         ex_branch     <= id_branch & id_valid;
         ex_pc         <= id_pc;
         ex_imm        <= id_imm;
         ex_rs1_data   <= id_rs1_data;
         ex_rs2_data   <= id_rs2_data;
         ex_rs1        <= id_rs1;
         ex_rs2        <= id_rs2;
         ex_rd         <= id_rd;
         alu_control   <= id_alucontrol;
         ex_alusrc_pc  <= id_alusrc_pc;
         ex_alusrc_imm <= id_alusrc_imm;
         ex_funct3     <= id_funct3;
      end
   end

   // MEM is the younger producer, so it wins over WB; x0 is never forwarded
   assign m1 = FWD_EN && mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1);
   assign w1 = FWD_EN && wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs1);
   assign m2 = FWD_EN && mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2);
   assign w2 = FWD_EN && wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs2);

   assign fwd_rs1       = m1 ? mem_result : w1 ? wb_result : ex_rs1_data;
   assign fwd_rs2       = m2 ? mem_result : w2 ? wb_result : ex_rs2_data;
   assign alu_a         = ex_alusrc_pc ? ex_pc : fwd_rs1;
   assign alu_b         = ex_alusrc_imm ? ex_imm : fwd_rs2;
   assign ex_store_data = fwd_rs2;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of id_ex_stage loading, forwarding, hazards, flush/stall and reset.
module tb_id_ex_stage;
   logic        clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
   logic        id_valid, id_uses_rs1, id_uses_rs2, id_alusrc_pc, id_alusrc_imm;
   logic        id_regwrite, id_memread, id_memwrite, id_branch;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [3:0]  id_alucontrol;
   logic [2:0]  id_funct3;
   logic        mem_regwrite, wb_regwrite;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_result, wb_result;
   logic        load_use_hold, ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
   logic [31:0] alu_a, alu_b, ex_store_data, ex_pc, ex_imm;
   logic [3:0]  alu_control;
   logic [4:0]  ex_rd;
   logic [2:0]  ex_funct3;
   int          n_tests = 0, n_fail = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
      .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_alucontrol(id_alucontrol),
      .id_alusrc_pc(id_alusrc_pc), .id_alusrc_imm(id_alusrc_imm), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
      .id_funct3(id_funct3), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
      .mem_result(mem_result), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
      .load_use_hold(load_use_hold), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
      .alu_control(alu_control), .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_imm(ex_imm),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_funct3(ex_funct3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_id();
      {id_valid, id_uses_rs1, id_uses_rs2, id_alusrc_pc, id_alusrc_imm} = '0;
      {id_regwrite, id_memread, id_memwrite, id_branch} = '0;
      {id_pc, id_rs1_data, id_rs2_data, id_imm} = '0;
      {id_rs1, id_rs2, id_rd, id_alucontrol, id_funct3} = '0;
      {mem_regwrite, wb_regwrite, mem_rd, wb_rd, mem_result, wb_result} = '0;
   endtask

   task automatic set_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2);
      clr_id();
      id_valid = 1'b1; id_regwrite = 1'b1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
      id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1; id_rs2_data = d2;
   endtask

   initial begin
      clr_id();
      #12;
      check("reset_valid", {31'd0, ex_valid}, 32'd0);
      check("reset_regwrite", {31'd0, ex_regwrite}, 32'd0);
      check("reset_aluctl", {28'd0, alu_control}, 32'd0);
      rst_n = 1'b1;
      tick();

      // add x3,x1,x2 with x1 from MEM, x2 from WB
      set_alu(5'd3, 5'd1, 5'd2, 32'hdead, 32'hbeef);
      id_pc = 32'h40;
      tick();
      clr_id();
      check("no_fwd_a", alu_a, 32'hdead);
      check("no_fwd_b", alu_b, 32'hbeef);
      check("load_valid", {31'd0, ex_valid}, 32'd1);
      check("load_rd", {27'd0, ex_rd}, 32'd3);
      check("load_pc", ex_pc, 32'h40);
      mem_regwrite = 1'b1; mem_rd = 5'd1; mem_result = 32'h10;
      wb_regwrite = 1'b1; wb_rd = 5'd2; wb_result = 32'h5;
      #1;
      check("fwd_mem_a", alu_a, 32'h10);
      check("fwd_wb_b", alu_b, 32'h5);

      // MEM and WB both write x4; MEM wins
      set_alu(5'd8, 5'd4, 5'd0, 32'h1, 32'h0);
      tick();
      clr_id();
      mem_regwrite = 1'b1; mem_rd = 5'd4; mem_result = 32'hAA;
      wb_regwrite = 1'b1; wb_rd = 5'd4; wb_result = 32'hBB;
      #1;
      check("fwd_prio_a", alu_a, 32'hAA);
      mem_regwrite = 1'b0;
      #1;
      check("fwd_wb_only_a", alu_a, 32'hBB);
      mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
      #1;
      check("x0_no_fwd_b", alu_b, 32'h0);
      check("x0_no_fwd_a", alu_a, 32'h1);

      // lw x5 then add x6,x5,x7
      clr_id();
      id_valid = 1'b1; id_memread = 1'b1; id_regwrite = 1'b1; id_rd = 5'd5;
      id_rs1 = 5'd2; id_uses_rs1 = 1'b1; id_alusrc_imm = 1'b1;
      tick();
      check("lw_memread", {31'd0, ex_memread}, 32'd1);
      set_alu(5'd6, 5'd5, 5'd7, 32'h0, 32'h7);
      #1;
      check("hold_on", {31'd0, load_use_hold}, 32'd1);
      tick();
      check("bubble_valid", {31'd0, ex_valid}, 32'd0);
      check("bubble_regwrite", {31'd0, ex_regwrite}, 32'd0);
      check("hold_off", {31'd0, load_use_hold}, 32'd0);
      tick();
      check("add_valid", {31'd0, ex_valid}, 32'd1);
      check("add_rd", {27'd0, ex_rd}, 32'd6);
      // rs2 match and rd=x0 cases of the hazard
      clr_id();
      id_valid = 1'b1; id_memread = 1'b1; id_rd = 5'd9;
      tick();
      set_alu(5'd1, 5'd2, 5'd9, 32'h0, 32'h0);
      #1;
      check("hold_rs2", {31'd0, load_use_hold}, 32'd1);
      id_uses_rs2 = 1'b0;
      #1;
      check("hold_unused_rs2", {31'd0, load_use_hold}, 32'd0);
      clr_id();
      id_valid = 1'b1; id_memread = 1'b1; id_rd = 5'd0;
      tick();
      set_alu(5'd1, 5'd0, 5'd0, 32'h0, 32'h0);
      #1;
      check("hold_x0", {31'd0, load_use_hold}, 32'd0);

      // flush with stall, then stall alone
      clr_id();
      id_valid = 1'b1; id_memwrite = 1'b1; id_pc = 32'h200; id_rd = 5'd11;
      id_alucontrol = 4'b0011;
      tick();
      check("sw_memwrite", {31'd0, ex_memwrite}, 32'd1);
      flush = 1'b1; stall = 1'b1;
      tick();
      flush = 1'b0; stall = 1'b0;
      check("flush_valid", {31'd0, ex_valid}, 32'd0);
      check("flush_memwrite", {31'd0, ex_memwrite}, 32'd0);
      tick();
      check("reload_valid", {31'd0, ex_valid}, 32'd1);
      stall = 1'b1;
      id_pc = 32'h300; id_rd = 5'd12; id_alucontrol = 4'b0101; id_memwrite = 1'b0; id_valid = 1'b0;
      tick();
      stall = 1'b0;
      check("stall_pc", ex_pc, 32'h200);
      check("stall_rd", {27'd0, ex_rd}, 32'd11);
      check("stall_aluctl", {28'd0, alu_control}, 32'h3);
      check("stall_valid", {31'd0, ex_valid}, 32'd1);
      check("stall_memwrite", {31'd0, ex_memwrite}, 32'd1);
      tick();
      check("invalid_load_valid", {31'd0, ex_valid}, 32'd0);

      // auipc and sw
      clr_id();
      id_valid = 1'b1; id_regwrite = 1'b1; id_alusrc_pc = 1'b1; id_alusrc_imm = 1'b1;
      id_pc = 32'h100; id_imm = 32'h2000; id_rs1_data = 32'h77; id_rd = 5'd10;
      tick();
      check("auipc_a", alu_a, 32'h100);
      check("auipc_b", alu_b, 32'h2000);
      check("auipc_aluctl", {28'd0, alu_control}, 32'h0);
      clr_id();
      id_valid = 1'b1; id_memwrite = 1'b1; id_alusrc_imm = 1'b1; id_imm = 32'h8;
      id_rs1 = 5'd2; id_rs2 = 5'd9; id_rs2_data = 32'h111; id_funct3 = 3'b010;
      tick();
      clr_id();
      mem_regwrite = 1'b1; mem_rd = 5'd9; mem_result = 32'h999;
      #1;
      check("sw_store_fwd", ex_store_data, 32'h999);
      check("sw_alu_b_imm", alu_b, 32'h8);
      check("sw_funct3", {29'd0, ex_funct3}, 32'h2);

      // asynchronous reset mid-run
      set_alu(5'd13, 5'd1, 5'd2, 32'h0, 32'h0);
      id_alucontrol = 4'b1001;
      tick();
      check("pre_rst_aluctl", {28'd0, alu_control}, 32'h9);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid", {31'd0, ex_valid}, 32'd0);
      check("async_rst_regwrite", {31'd0, ex_regwrite}, 32'd0);
      check("async_rst_aluctl", {28'd0, alu_control}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
